uvma_st_rr_arb: RTL
===================

# uvma_st_rr_arb

Round-robin arbiter that shares one `uvma_st` streaming channel among `NUM_REQ` requesters. A requester holds the channel for a full burst, which ends on a handshake with `last` set. The arbiter sits between the sequencer-driven requester ports and the single `st` channel driven onto `uvma_st_if`. It enforces a maximum burst length and flags any burst that exceeds it.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2–16.
- `DATA_WIDTH`, default 32: beat data width in bits.
- `MAX_BEATS`, default 16: maximum beats per grant, legal range ≥2.
- `clk`  in  1  the single clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  per-requester beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  per-requester last-beat flag.
- `req_ready`  out  NUM_REQ  per-requester ready.
- `st_valid`  out  1  channel beat valid.
- `st_data`  out  DATA_WIDTH  channel beat data.
- `st_last`  out  1  channel last-beat flag.
- `st_ready`  in  1  channel ready.
- `gnt_id`  out  $clog2(NUM_REQ)  index of the current or most recent grant.
- `busy`  out  1  high while a grant is held.
- `burst_err`  out  1  one-cycle pulse when a burst is truncated at MAX_BEATS.

## Operation
- The FSM has two states, IDLE and BUSY. `busy` is high exactly when the state is BUSY.
- IDLE behaviour:
  - `st_valid`=0 and all `req_ready`=0.
  - If any `req_valid` bit is set, the winner is the first set index searching upward from `rr_ptr`, wrapping NUM_REQ-1→0.
  - `gnt_id` is registered to the winner, `beat_cnt` is cleared, and the FSM moves to BUSY.
- BUSY behaviour:
  - `st_valid`=`req_valid[gnt_id]`, `st_data`=`req_data[gnt_id]`, `st_last`=`req_last[gnt_id]`.
  - `req_ready[gnt_id]`=`st_ready`; all other `req_ready` bits are 0.
  - `st_data` and `st_last` are don't-care when `st_valid`=0, but the implementation drives them muxed from `gnt_id` regardless.
- A handshake is `st_valid & st_ready`. Each handshake increments `beat_cnt`, which is $clog2(MAX_BEATS+1) bits wide and saturates at MAX_BEATS.
- A grant is released on either of two handshakes:
  - A handshake with `st_last`=1: normal end of burst.
  - A handshake with `st_last`=0 when `beat_cnt`==MAX_BEATS-1: truncation. `burst_err` pulses high for the cycle after this handshake, and the requester's remaining beats are arbitrated as a new burst.
- On release, the FSM returns to IDLE and `rr_ptr` is set to `gnt_id`+1, wrapping NUM_REQ→0.
- Granted requester deasserts `req_valid` mid-burst: the grant is held and `st_valid`=0. No other requester is served until the burst is released. There is no timeout.
- `req_valid` changes on non-granted ports have no effect while BUSY.
- `gnt_id` holds its value in IDLE, so it always reports the most recent grant.

## Timing
- Reset values, applied when `reset_n`=0 at a rising edge:
  - State IDLE, `rr_ptr`=0, `gnt_id`=0, `beat_cnt`=0.
  - `busy`=0, `burst_err`=0, `st_valid`=0, `req_ready`=0.
- Reset in the middle of a burst aborts it. In-flight beats are lost and there is no error pulse.
- Arbitration latency: a `req_valid` sampled high in IDLE at edge k drives `st_valid` high from edge k+1 onward.
- The handshake at edge m that releases a grant gives IDLE during cycle m..m+1, and the next grant takes effect at m+1. The minimum gap between bursts is therefore exactly one dead cycle.
- A continuous single-beat stream from one requester with `st_ready`=1 achieves 50% throughput.
- A burst of B beats with no backpressure occupies the channel for B cycles, plus 1 arbitration cycle.
- `req_ready` and `st_valid` are combinational from registered state plus `st_ready`/`req_valid`. There is no combinational path from `st_ready` to `st_valid`.
- Requesters must hold data and last stable while valid is high and ready is low. The arbiter does not register beat data.

## Test plan
- Single burst:
  - Stimulus: NUM_REQ=4, req 2 presents a 3-beat burst (D0, D1, D2 with last) at cycle 0, `st_ready`=1.
  - Required response: `gnt_id`=2 and `busy`=1 from cycle 1; beats on `st_*` in cycles 1–3; `busy`=0 in cycle 4; `rr_ptr`=3.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously assert single-beat bursts.
  - Required response: grant order 0,1,2,3,0,1, with grants every 2 cycles and no starvation.
- Backpressure:
  - Stimulus: `st_ready`=0 for 5 cycles during beat 2 of a 4-beat burst from req 1.
  - Required response: `st_data` stable; `req_ready[1]`=0 for those cycles; grant not switched despite req 0 and req 3 being active.
- Truncation:
  - Stimulus: MAX_BEATS=4, req 0 sends 6 beats and only beat 6 has last.
  - Required response: `burst_err` pulses once after the 4th handshake; the FSM goes to IDLE and re-arbitrates; the remaining 2 beats go out as a new grant (to req 0 if it is the only requester).
- Valid gaps:
  - Stimulus: granted req 1 drops `req_valid` for 3 cycles mid-burst while req 0 is pending.
  - Required response: `st_valid`=0 for those 3 cycles; `gnt_id` stays 1; req 0 is served only after req 1's last beat.
- Reset mid-burst:
  - Stimulus: `reset_n`=0 during beat 2 of a burst from req 3.
  - Required response: the next edge gives `busy`=0, `st_valid`=0, `gnt_id`=0; after release with all requests active, the first grant goes to req 0.

Source files
------------

// File: rtl/uvma_st_rr_arb.sv
// Round-robin arbiter that hands one uvma_st channel to a single requester for a whole burst.
// Bursts end on a last-beat handshake or are cut at MAX_BEATS, which raises a one-cycle burst_err.
module uvma_st_rr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          st_valid,
  output logic [DATA_WIDTH-1:0]         st_data,
  output logic                          st_last,
  input  logic                          st_ready,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          busy,
  output logic                          burst_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BEATS);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);
  localparam logic [IW-1:0] ID_TOP   = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   rr_ptr_d;
  logic [IW-1:0]   gnt_id_q;
  logic [CW-1:0]   beat_cnt_q;
  logic [CW-1:0]   beat_cnt_d;
  logic            burst_err_q;

  logic [IW-1:0]   winner;
  logic            any_req;
  logic            hs;
  logic            release_burst;

  // First requesting index at or above rr_ptr_q, wrapping to 0.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = rr_ptr_q;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        winner  = IW'(idx);
      end
    end
  end

  assign busy      = (state_q == BUSY);
  assign st_valid  = busy & req_valid[gnt_id_q];
  assign st_data   = req_data[int'(gnt_id_q)*DATA_WIDTH +: DATA_WIDTH];
  assign st_last   = req_last[gnt_id_q];
  assign gnt_id    = gnt_id_q;
  assign burst_err = burst_err_q;

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[gnt_id_q] = st_ready;
  end

  assign hs            = st_valid & st_ready;
  assign release_burst = hs & (st_last | (beat_cnt_q == CNT_LAST));
  assign rr_ptr_d      = (gnt_id_q == ID_TOP) ? '0 : gnt_id_q + 1'b1;
  assign beat_cnt_d    = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      burst_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_id_q   <= winner;
            beat_cnt_q <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (hs) beat_cnt_q <= beat_cnt_d;
          if (release_burst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= rr_ptr_d;
            // Only a cut burst (no last seen) is an error.
            burst_err_q <= ~st_last;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
